// File: rtl/calc_pkg.sv
// Shared types and key codes for the calculator entry controller.
// FSM state encoding and the keypad command codes.
package calc_pkg;

  typedef enum logic [2:0] {
    ENTRY_A = 3'd0,
    ENTRY_B = 3'd1,
    START   = 3'd2,
    WAIT    = 3'd3,
    SHOW    = 3'd4
  } calc_state_t;

  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;

endpackage

// File: rtl/calc_digit_acc.sv
// Signed decimal operand accumulator: magnitude, digit count, sign.
// Ports: clk, rst (async low), clr_i, dig_en_i, dig_i, tog_i -> val_o, cnt_o.
module calc_digit_acc #(
  parameter int W      = 8,
  parameter int DIGITS = 2,
  localparam int CW    = $clog2(DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          dig_en_i,
  input  logic [3:0]    dig_i,
  input  logic          tog_i,
  output logic [W-1:0]  val_o,
  output logic [CW-1:0] cnt_o
);

  localparam logic [W-1:0]  TEN  = W'(10);
  localparam logic [CW-1:0] FULL = CW'(DIGITS);

  logic [W-1:0]  mag_q, mag_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sign_q, sign_d;

  always_comb begin
    mag_d  = mag_q;
    cnt_d  = cnt_q;
    sign_d = sign_q;
    if (clr_i) begin
      mag_d  = '0;
      cnt_d  = '0;
      sign_d = 1'b0;
    end else begin
      // Full operand drops further digits, so mag never overflows.
      if (dig_en_i && cnt_q != FULL) begin
        mag_d = mag_q * TEN + W'(dig_i);
        cnt_d = cnt_q + 1'b1;
      end
      if (tog_i)
        sign_d = ~sign_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mag_q  <= '0;
      cnt_q  <= '0;
      sign_q <= 1'b0;
    end else begin
      mag_q  <= mag_d;
      cnt_q  <= cnt_d;
      sign_q <= sign_d;
    end
  end

  assign val_o = sign_q ? (~mag_q + 1'b1) : mag_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/calc_entry_controller.sv
// Keypad-to-datapath sequencer: builds two signed operands, launches op,
// holds result under valid/ready. Ports: clk, rst (async low), key_*,
// op_a/op_b/op_start/op_done/op_result, result/res_valid/res_ready, err,
// state_o. Optional watchdog in WAIT enabled by macro CALC_TIMEOUT_EN.
module calc_entry_controller
  import calc_pkg::*;
#(
  parameter int W           = 8,
  parameter int DIGITS      = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           key_valid,
  input  logic [3:0]     key_code,
  output logic           key_ready,
  output logic [W-1:0]   op_a,
  output logic [W-1:0]   op_b,
  output logic           op_start,
  input  logic           op_done,
  input  logic [2*W-1:0] op_result,
  output logic [2*W-1:0] result,
  output logic           res_valid,
  input  logic           res_ready,
  output logic           err,
  output logic [2:0]     state_o
);

  localparam int CW = $clog2(DIGITS + 1);

  if (10 ** DIGITS - 1 > 2 ** (W - 1) - 1) begin : g_chk_w
    $error("DIGITS too large for W");
  end
  if (TIMEOUT_CYC < 2) begin : g_chk_t
    $error("TIMEOUT_CYC must be >= 2");
  end

  calc_state_t    state_q, state_d;
  logic [2*W-1:0] result_q;
  logic [CW-1:0]  cnt_a, cnt_b;
  logic           acc, is_dig, k_b, k_c;
  logic           hs, tmo, clr;
  logic           in_a, in_b;

  assign key_ready = (state_q == ENTRY_A) ||
                     (state_q == ENTRY_B) ||
                     (state_q == SHOW);

  assign acc    = key_valid & key_ready;
  assign is_dig = key_code < 4'd10;
  assign k_b    = acc & (key_code == KEY_B);
  assign k_c    = acc & (key_code == KEY_C);
  assign hs     = (state_q == SHOW) & res_ready;
  assign in_a   = state_q == ENTRY_A;
  assign in_b   = state_q == ENTRY_B;

`ifdef CALC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tcnt_q, tcnt_d;

  // Counts WAIT cycles; a simultaneous op_done takes priority.
  assign tcnt_d = (state_q == WAIT) ? tcnt_q + 1'b1 : '0;
  assign tmo    = (state_q == WAIT) && (tcnt_q == TLAST) && !op_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tcnt_q <= '0;
    else      tcnt_q <= tcnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  assign clr = k_c | hs | tmo;

  calc_digit_acc #(.W(W), .DIGITS(DIGITS)) u_acc_a (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clr),
    .dig_en_i (acc & in_a & is_dig),
    .dig_i    (key_code),
    .tog_i    (k_b & in_a),
    .val_o    (op_a),
    .cnt_o    (cnt_a)
  );

  calc_digit_acc #(.W(W), .DIGITS(DIGITS)) u_acc_b (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clr),
    .dig_en_i (acc & in_b & is_dig),
    .dig_i    (key_code),
    .tog_i    (k_b & in_b),
    .val_o    (op_b),
    .cnt_o    (cnt_b)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ENTRY_A: begin
        if (k_c)
          state_d = ENTRY_A;
        else if (acc && key_code == KEY_A && cnt_a != '0)
          state_d = ENTRY_B;
      end
      ENTRY_B: begin
        if (k_c)
          state_d = ENTRY_A;
        else if (acc && key_code == KEY_D && cnt_b != '0)
          state_d = START;
      end
      START:   state_d = WAIT;
      WAIT: begin
        if (op_done)  state_d = SHOW;
        else if (tmo) state_d = ENTRY_A;
      end
      SHOW: begin
        if (hs || k_c) state_d = ENTRY_A;
      end
      default: state_d = ENTRY_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ENTRY_A;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      result_q <= '0;
    else if (state_q == WAIT && op_done)
      result_q <= op_result;
  end

  assign op_start  = state_q == START;
  assign res_valid = state_q == SHOW;
  assign result    = result_q;
  assign err       = tmo;
  assign state_o   = state_q;

endmodule
